// File: rtl/dbg_view_pkg.sv
// Shared types and constants for the debug display view sequencer.
// The advance rule lives here so every consumer wraps views identically.
package dbg_view_pkg;

    typedef enum logic [1:0] {
        S_MANUAL = 2'd0,
        S_AUTO   = 2'd1,
        S_STEP   = 2'd2,
        S_HOLD   = 2'd3
    } view_state_t;

    localparam logic [2:0] VIEW_PC_STATE   = 3'd0;
    localparam logic [2:0] VIEW_ALU_A      = 3'd1;
    localparam logic [2:0] VIEW_ALU_B      = 3'd2;
    localparam logic [2:0] VIEW_ALU_OUT    = 3'd3;
    localparam logic [2:0] VIEW_NEXT_STATE = 3'd4;

    // Last valid view and any out-of-range view both wrap to view 0.
    function automatic logic [2:0] advance_view(input logic [2:0]  view,
                                                input int unsigned num_views);
        logic [2:0] nxt;
        if ({29'd0, view} >= num_views - 32'd1) begin
            nxt = VIEW_PC_STATE;
        end else begin
            nxt = view + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Step key 2-flop synchronizer plus rising-edge detect; Rise is valid 2 clocks after the key is first sampled.
// No backpressure; Arm re-seeds the history so a key already held cannot produce a Rise.
module key_sync_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic KeyIn,
    input  logic Arm,
    output logic Rise
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    // On Arm the history takes the level sync2 is about to hold, so the first armed cycle sees no edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= KeyIn;
            sync2_q <= sync1_q;
            hist_q  <= Arm ? sync1_q : sync2_q;
        end
    end

    assign Rise = sync2_q & ~hist_q;

endmodule

// File: rtl/view_sequencer.sv
// Debug display view select: manual, timed auto-cycle, key step and hold modes; 1-clock Mode/Sw latency.
// No backpressure; outputs are registered and ViewChange pulses on the cycle a new ViewSel appears.
module view_sequencer
    import dbg_view_pkg::*;
#(
    parameter int NUM_VIEWS    = 5,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [2:0] Sw,
    input  logic [1:0] Mode,
    input  logic       StepKey,
    output logic [2:0] ViewSel,
    output logic       ViewChange,
    output logic       AutoActive
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    view_state_t      state_q, state_d;
    logic [2:0]       view_q, view_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chg_q;
    logic             auto_q;
    logic             mode_chg;
    logic             arm;
    logic             rise;

    key_sync_edge u_key (
        .Clk   (Clk),
        .Reset (Reset),
        .KeyIn (StepKey),
        .Arm   (arm),
        .Rise  (rise)
    );

    // A mode change in the same cycle as a key edge or terminal count suppresses the advance.
    always_comb begin
        state_d  = view_state_t'(Mode);
        mode_chg = (state_d != state_q);
        arm      = (state_d == S_STEP) && (state_q != S_STEP);
        view_d   = view_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_MANUAL: view_d = Sw;
            S_AUTO: begin
                if (!mode_chg) begin
                    if (cnt_q == CNT_LAST) begin
                        view_d = advance_view(view_q, NUM_VIEWS);
                        cnt_d  = '0;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_STEP: begin
                if (!mode_chg && rise) begin
                    view_d = advance_view(view_q, NUM_VIEWS);
                end
            end
            S_HOLD: ;
            default: ;
        endcase
        if (mode_chg && (state_q == S_AUTO || state_d == S_AUTO)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_MANUAL;
            view_q  <= VIEW_PC_STATE;
            cnt_q   <= '0;
            chg_q   <= 1'b0;
            auto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            view_q  <= view_d;
            cnt_q   <= cnt_d;
            chg_q   <= (view_d != view_q);
            auto_q  <= (state_d == S_AUTO);
        end
    end

    assign ViewSel    = view_q;
    assign ViewChange = chg_q;
    assign AutoActive = auto_q;

endmodule
